// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode table, instruction field positions and decode FSM
// encoding shared by the pipeline stages.
package cpu_pkg;

  localparam int OPC_W = 5;
  localparam int REG_W = 3;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 5;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 2;

  localparam logic [OPC_W-1:0] OP_NOP = 5'h00;
  localparam logic [OPC_W-1:0] OP_ADD = 5'h01;
  localparam logic [OPC_W-1:0] OP_SUB = 5'h02;
  localparam logic [OPC_W-1:0] OP_AND = 5'h03;
  localparam logic [OPC_W-1:0] OP_OR  = 5'h04;
  localparam logic [OPC_W-1:0] OP_MOV = 5'h05;
  localparam logic [OPC_W-1:0] OP_LDD = 5'h06;
  localparam logic [OPC_W-1:0] OP_STD = 5'h07;
  localparam logic [OPC_W-1:0] OP_BEQ = 5'h08;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_BUBBLE = 1'b1
  } state_e;

  typedef struct packed {
    logic use1;
    logic use2;
    logic reg_write;
    logic mem_read;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational opcode table; undefined opcodes
// collapse to NOP with no register reads and no side effects.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [OPC_W-1:0] op_norm,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl    = '0;
    op_norm = opcode;
    unique case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        ctrl.use1      = 1'b1;
        ctrl.use2      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_MOV: begin
        ctrl.use1      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LDD: begin
        ctrl.use1      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      OP_STD, OP_BEQ: begin
        ctrl.use1 = 1'b1;
        ctrl.use2 = 1'b1;
      end
      OP_NOP: begin
        ctrl = '0;
      end
      default: begin
        op_norm = OP_NOP;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode, load-use bubble FSM and ID/EX register.
// DECODE_WB_BYPASS_EN forwards the write-back port into the operands.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_instr_valid,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_ready,
  input  logic               i_flush,
  input  logic               i_ex_stall,
  input  logic               i_ex_mem_read,
  input  logic [REG_W-1:0]   i_ex_rdst,
  output logic               o_rf_read1,
  output logic               o_rf_read2,
  output logic [REG_W-1:0]   o_rf_addr1,
  output logic [REG_W-1:0]   o_rf_addr2,
  input  logic [DATA_W-1:0]  i_rf_data1,
  input  logic [DATA_W-1:0]  i_rf_data2,
  input  logic               i_wb_write,
  input  logic [REG_W-1:0]   i_wb_addr,
  input  logic [DATA_W-1:0]  i_wb_data,
  output logic               o_valid,
  output logic [OPC_W-1:0]   o_opcode,
  output logic [REG_W-1:0]   o_rdst,
  output logic [REG_W-1:0]   o_rsrc1,
  output logic [REG_W-1:0]   o_rsrc2,
  output logic [DATA_W-1:0]  o_data1,
  output logic [DATA_W-1:0]  o_data2,
  output logic               o_reg_write,
  output logic               o_mem_read
);

  logic [OPC_W-1:0]  opc;
  logic [OPC_W-1:0]  opc_dec;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  ctrl_t             ctrl;
  state_e            state;
  logic              src_hit;
  logic              hazard;
  logic              bubble;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;

  assign opc = i_instr[OPC_HI:OPC_LO];
  assign rd  = i_instr[RD_HI:RD_LO];
  assign rs1 = i_instr[RS1_HI:RS1_LO];
  assign rs2 = i_instr[RS2_HI:RS2_LO];

  instr_decoder u_dec (
    .opcode  (opc),
    .op_norm (opc_dec),
    .ctrl    (ctrl)
  );

  assign o_rf_read1 = i_instr_valid & ctrl.use1;
  assign o_rf_read2 = i_instr_valid & ctrl.use2;
  assign o_rf_addr1 = rs1;
  assign o_rf_addr2 = rs2;

  // o_valid here means the load in execute is a real instruction
  assign src_hit = (ctrl.use1 && rs1 == i_ex_rdst) ||
                   (ctrl.use2 && rs2 == i_ex_rdst);
  assign hazard  = i_instr_valid & i_ex_mem_read & o_valid & src_hit;
  assign bubble  = (state == S_RUN) & hazard;
  assign o_ready = !i_ex_stall && !bubble;

`ifdef DECODE_WB_BYPASS_EN
  always_comb begin
    d1 = i_rf_data1;
    d2 = i_rf_data2;
    if (i_wb_write && ctrl.use1 && i_wb_addr == rs1) d1 = i_wb_data;
    if (i_wb_write && ctrl.use2 && i_wb_addr == rs2) d2 = i_wb_data;
  end

  logic unused;
  assign unused = ^i_instr[1:0];
`else
  assign d1 = i_rf_data1;
  assign d2 = i_rf_data2;

  logic unused;
  assign unused = ^{i_instr[1:0], i_wb_write, i_wb_addr, i_wb_data};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_RUN;
      o_valid     <= 1'b0;
      o_opcode    <= OP_NOP;
      o_rdst      <= '0;
      o_rsrc1     <= '0;
      o_rsrc2     <= '0;
      o_data1     <= '0;
      o_data2     <= '0;
      o_reg_write <= 1'b0;
      o_mem_read  <= 1'b0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (hazard && !i_ex_stall && !i_flush) state <= S_BUBBLE;
        end
        S_BUBBLE: begin
          if (i_flush || !i_ex_stall) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase

      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (!i_ex_stall) begin
        if (bubble) begin
          o_valid <= 1'b0;
        end else begin
          o_valid     <= i_instr_valid;
          o_opcode    <= opc_dec;
          o_rdst      <= rd;
          o_rsrc1     <= rs1;
          o_rsrc2     <= rs2;
          o_data1     <= d1;
          o_data2     <= d2;
          o_reg_write <= ctrl.reg_write;
          o_mem_read  <= ctrl.mem_read;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage; expectations are
// queued when an instruction is presented and popped when it issues.
module tb_decode_stage;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        ready;
  logic        flush;
  logic        ex_stall;
  logic        ex_mem_read;
  logic [2:0]  ex_rdst;
  logic        rf_read1;
  logic        rf_read2;
  logic [2:0]  rf_addr1;
  logic [2:0]  rf_addr2;
  logic [15:0] rf_data1;
  logic [15:0] rf_data2;
  logic        wb_write;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        valid;
  logic [4:0]  opcode;
  logic [2:0]  rdst;
  logic [2:0]  rsrc1;
  logic [2:0]  rsrc2;
  logic [15:0] data1;
  logic [15:0] data2;
  logic        reg_write;
  logic        mem_read;

  logic [15:0] rf [8];

  always #5 clk = ~clk;

  assign rf_data1 = rf[rf_addr1];
  assign rf_data2 = rf[rf_addr2];

  decode_stage dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_instr_valid (instr_valid),
    .i_instr       (instr),
    .o_ready       (ready),
    .i_flush       (flush),
    .i_ex_stall    (ex_stall),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rdst     (ex_rdst),
    .o_rf_read1    (rf_read1),
    .o_rf_read2    (rf_read2),
    .o_rf_addr1    (rf_addr1),
    .o_rf_addr2    (rf_addr2),
    .i_rf_data1    (rf_data1),
    .i_rf_data2    (rf_data2),
    .i_wb_write    (wb_write),
    .i_wb_addr     (wb_addr),
    .i_wb_data     (wb_data),
    .o_valid       (valid),
    .o_opcode      (opcode),
    .o_rdst        (rdst),
    .o_rsrc1       (rsrc1),
    .o_rsrc2       (rsrc2),
    .o_data1       (data1),
    .o_data2       (data2),
    .o_reg_write   (reg_write),
    .o_mem_read    (mem_read)
  );

  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        rw;
    logic        mr;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // reference table: {use1, use2, reg_write, mem_read}
  function automatic logic [3:0] ref_ctrl(input logic [4:0] op);
    case (op)
      5'd1, 5'd2, 5'd3, 5'd4: ref_ctrl = 4'b1110;
      5'd5:                   ref_ctrl = 4'b1010;
      5'd6:                   ref_ctrl = 4'b1011;
      5'd7, 5'd8:             ref_ctrl = 4'b1100;
      default:                ref_ctrl = 4'b0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] op, input logic [2:0] rd,
                     input logic [2:0] s1, input logic [2:0] s2);
    instr       = {op, rd, s1, s2, 2'b00};
    instr_valid = 1'b1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] rd,
                       input logic [2:0] s1, input logic [2:0] s2);
    logic [3:0] c;
    exp_t       e;
    c = ref_ctrl(op);
    put(op, rd, s1, s2);
    e.opc = (c == 4'b0000) ? 5'd0 : op;
    e.rd  = rd;
    e.rs1 = s1;
    e.rs2 = s2;
    e.d1  = rf[s1];
    e.d2  = rf[s2];
    if (BYP && wb_write && c[3] && wb_addr == s1) e.d1 = wb_data;
    if (BYP && wb_write && c[2] && wb_addr == s2) e.d2 = wb_data;
    e.rw  = c[1];
    e.mr  = c[0];
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got issue want none queued", tag);
      return;
    end
    e    = sb.pop_front();
    last = e;
    chk({tag, ".valid"}, valid, 1);
    chk({tag, ".opc"},   opcode, e.opc);
    chk({tag, ".rd"},    rdst, e.rd);
    chk({tag, ".rs1"},   rsrc1, e.rs1);
    chk({tag, ".rs2"},   rsrc2, e.rs2);
    chk({tag, ".d1"},    data1, e.d1);
    chk({tag, ".d2"},    data2, e.d2);
    chk({tag, ".rw"},    reg_write, e.rw);
    chk({tag, ".mr"},    mem_read, e.mr);
  endtask

  logic [4:0] ops [10];

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    flush       = 1'b0;
    ex_stall    = 1'b0;
    ex_mem_read = 1'b0;
    ex_rdst     = '0;
    wb_write    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0100 + 16'(i);
    rf[1] = 16'h0005;
    rf[2] = 16'h0007;

    step();
    step();
    chk("rst.valid", valid, 0);
    chk("rst.opc",   opcode, 0);
    chk("rst.rd",    rdst, 0);
    chk("rst.rs1",   rsrc1, 0);
    chk("rst.rs2",   rsrc2, 0);
    chk("rst.d1",    data1, 0);
    chk("rst.d2",    data2, 0);
    chk("rst.rw",    reg_write, 0);
    chk("rst.mr",    mem_read, 0);
    reset = 1'b0;
    #1;
    chk("rst.ready", ready, 1);

    // ADD r3, r1, r2
    drive(5'd1, 3'd3, 3'd1, 3'd2);
    #1;
    chk("add.rd1",   rf_read1, 1);
    chk("add.rd2",   rf_read2, 1);
    chk("add.a1",    rf_addr1, 1);
    chk("add.a2",    rf_addr2, 2);
    chk("add.ready", ready, 1);
    step();
    pop_cmp("add");
    chk("add.lit_d1", data1, 16'h0005);
    chk("add.lit_d2", data2, 16'h0007);

    // opcode sweep, back to back, includes undefined encodings
    ops = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd7,
            5'd8, 5'd9, 5'd0, 5'd31, 5'd6};
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], 3'(i), 3'(i + 1), 3'(i + 2));
      #1;
      chk("sweep.rd1", rf_read1, ref_ctrl(ops[i]) >> 3);
      chk("sweep.rd2", rf_read2, (ref_ctrl(ops[i]) >> 2) & 1);
      step();
      pop_cmp("sweep");
    end
    instr_valid = 1'b0;
    #1;
    chk("idle.rd1", rf_read1, 0);
    step();
    chk("idle.valid", valid, 0);

    // load-use on rsrc1
    drive(5'd6, 3'd4, 3'd1, 3'd0);
    step();
    pop_cmp("ldd");
    ex_mem_read = 1'b1;
    ex_rdst     = 3'd4;
    drive(5'd1, 3'd5, 3'd4, 3'd1);
    #1;
    chk("haz.ready", ready, 0);
    step();
    chk("haz.bubble", valid, 0);
    ex_mem_read = 1'b0;
    #1;
    chk("haz.ready2", ready, 1);
    step();
    pop_cmp("haz.add");

    // load-use on rsrc2
    drive(5'd6, 3'd6, 3'd2, 3'd0);
    step();
    pop_cmp("ldd2");
    ex_mem_read = 1'b1;
    ex_rdst     = 3'd6;
    drive(5'd2, 3'd1, 3'd2, 3'd6);
    #1;
    chk("haz2.ready", ready, 0);
    step();
    chk("haz2.bubble", valid, 0);
    ex_mem_read = 1'b0;
    step();
    pop_cmp("haz2.sub");

    // unused source matching the load destination is not a hazard
    drive(5'd6, 3'd4, 3'd1, 3'd0);
    step();
    pop_cmp("ldd3");
    ex_mem_read = 1'b1;
    ex_rdst     = 3'd4;
    drive(5'd5, 3'd2, 3'd1, 3'd4);
    #1;
    chk("nohaz.ready", ready, 1);
    step();
    pop_cmp("nohaz.mov");
    ex_mem_read = 1'b0;

    // execute stall holds ID/EX for three cycles
    drive(5'd2, 3'd7, 3'd3, 3'd4);
    step();
    pop_cmp("pre_stall");
    ex_stall = 1'b1;
    drive(5'd1, 3'd1, 3'd2, 3'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.ready", ready, 0);
      step();
      chk("stall.valid", valid, 1);
      chk("stall.opc",   opcode, last.opc);
      chk("stall.rd",    rdst, last.rd);
      chk("stall.rs1",   rsrc1, last.rs1);
      chk("stall.rs2",   rsrc2, last.rs2);
      chk("stall.d1",    data1, last.d1);
      chk("stall.d2",    data2, last.d2);
      chk("stall.rw",    reg_write, last.rw);
    end
    ex_stall = 1'b0;
    #1;
    chk("stall.ready_end", ready, 1);
    step();
    pop_cmp("post_stall");

    // flush together with a hazard: no bubble cycle follows
    drive(5'd6, 3'd4, 3'd0, 3'd0);
    step();
    pop_cmp("ldd4");
    ex_mem_read = 1'b1;
    ex_rdst     = 3'd4;
    flush       = 1'b1;
    put(5'd1, 3'd5, 3'd4, 3'd1);
    #1;
    chk("flush.ready0", ready, 0);
    step();
    flush       = 1'b0;
    ex_mem_read = 1'b0;
    chk("flush.valid", valid, 0);
    drive(5'd1, 3'd5, 3'd4, 3'd1);
    #1;
    chk("flush.ready1", ready, 1);
    step();
    pop_cmp("flush.add");

    // reset aborts a bubble; stall right after reset drops ready
    drive(5'd6, 3'd4, 3'd0, 3'd0);
    step();
    pop_cmp("ldd5");
    ex_mem_read = 1'b1;
    ex_rdst     = 3'd4;
    put(5'd1, 3'd5, 3'd4, 3'd1);
    step();
    chk("rbub.bubble", valid, 0);
    ex_mem_read = 1'b0;
    reset       = 1'b1;
    ex_stall    = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rbub.ready_stall", ready, 0);
    chk("rbub.valid", valid, 0);
    ex_stall = 1'b0;
    #1;
    chk("rbub.ready", ready, 1);

    // reset aborts a stall with a valid instruction held
    drive(5'd3, 3'd2, 3'd5, 3'd6);
    step();
    pop_cmp("pre_rst_stall");
    ex_stall = 1'b1;
    put(5'd4, 3'd1, 3'd1, 3'd1);
    step();
    chk("rstall.hold", valid, 1);
    reset = 1'b1;
    step();
    reset       = 1'b0;
    ex_stall    = 1'b0;
    instr_valid = 1'b0;
    chk("rstall.valid", valid, 0);
    chk("rstall.opc",   opcode, 0);
    chk("rstall.d1",    data1, 0);
    step();

    // write-back bypass; r0 is an ordinary register
    rf[2]    = 16'h1111;
    rf[0]    = 16'h0ABC;
    wb_write = 1'b1;
    wb_addr  = 3'd2;
    wb_data  = 16'hBEEF;
    drive(5'd1, 3'd6, 3'd2, 3'd0);
    step();
    pop_cmp("byp");
    chk("byp.lit_d1", data1, BYP ? 16'hBEEF : 16'h1111);
    chk("byp.r0",     data2, 16'h0ABC);
    drive(5'd5, 3'd1, 3'd3, 3'd2);
    step();
    pop_cmp("byp.unused_src");
    chk("byp.lit_d2", data2, 16'h1111);
    wb_write = 1'b0;
    drive(5'd1, 3'd6, 3'd2, 3'd2);
    step();
    pop_cmp("byp.off");
    instr_valid = 1'b0;
    step();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb.leftover: got %0d want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 16, register and operand data width.
REQ-002 Parameter INSTR_W, default 16, instruction width.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_instr_valid  in  1  fetch stage presents a valid instruction.
REQ-006 i_instr  in  INSTR_W  fields: [15:11] opcode, [10:8] rdst, [7:5] rsrc1, [4:2] rsrc2.
REQ-007 o_ready  out  1  decode accepts i_instr this cycle.
REQ-008 i_flush  in  1  squash the instruction held in decode and the ID/EX register.
REQ-009 i_ex_stall  in  1  execute stage cannot accept; hold the ID/EX register.
REQ-010 i_ex_mem_read, i_ex_rdst  in  1, 3  the instruction now in execute is a load, and its destination.
REQ-011 o_rf_read1, o_rf_read2, o_rf_addr1, o_rf_addr2  out  1, 1, 3, 3  register file read strobes and addresses.
REQ-012 i_rf_data1, i_rf_data2  in  DATA_W  combinational register file read data.
REQ-013 i_wb_write, i_wb_addr, i_wb_data  in  1, 3, DATA_W  write-back port, also routed to the register file.
REQ-014 o_valid, o_opcode, o_rdst, o_rsrc1, o_rsrc2  out  1, 5, 3, 3, 3  ID/EX register contents.
REQ-015 o_data1, o_data2, o_reg_write, o_mem_read  out  DATA_W, DATA_W, 1, 1  ID/EX operands and control.

Function
REQ-016 The block SHALL drive o_rf_addr1/2 from rsrc1/rsrc2 and o_rf_read1/2 from per-opcode "uses source" flags, gated by i_instr_valid.
REQ-017 ID/EX register update, in priority order: reset > i_flush (o_valid<=0) > i_ex_stall (hold all) > bubble (o_valid<=0, other fields don't-care) > load (o_valid<=i_instr_valid, all fields from decode).
REQ-018 Load-use hazard: i_instr_valid & i_ex_mem_read & o_valid & (used rsrc == i_ex_rdst).
REQ-019 FSM states: RUN, BUBBLE; RUN->BUBBLE on hazard when not stalled/flushed; BUBBLE->RUN unconditionally after one cycle unless i_ex_stall (stay) or i_flush (go RUN).
REQ-020 o_ready SHALL be 0 in RUN with hazard, 0 whenever i_ex_stall, 1 otherwise; fetch holds i_instr while o_ready=0.
REQ-021 Latency: an accepted instruction SHALL appear on the ID/EX outputs exactly one cycle after acceptance.
REQ-022 o_reg_write/o_mem_read SHALL come from an opcode table; undefined opcodes decode as NOP (both 0, no reads).
REQ-023 Simultaneous i_flush and hazard: flush wins, no bubble cycle is counted, FSM returns to RUN.
REQ-024 Register index 0 is an ordinary register; no hard-wired zero.

Reset
REQ-025 On i_reset: FSM=RUN, o_valid=0, o_opcode=NOP, o_rdst/o_rsrc1/o_rsrc2=0, o_data1/o_data2=0, o_reg_write=0, o_mem_read=0.
REQ-026 Reset during BUBBLE or stall SHALL abort it; the first cycle after reset deasserts o_ready only if i_ex_stall.

Configuration
REQ-027 Macro DECODE_WB_BYPASS_EN defined: if i_wb_write and i_wb_addr equals a used source address, the corresponding operand SHALL be latched from i_wb_data instead of i_rf_data.
REQ-028 Macro DECODE_WB_BYPASS_EN undefined: operands always come from i_rf_data1/2; the write-back unit guarantees write-before-read ordering.

Structure
REQ-029 Shared package cpu_pkg SHALL hold the opcode constants, the NOP encoding, the instruction field positions and the FSM state encoding.
REQ-030 Sub-module instr_decoder (combinational opcode table to control flags) SHALL be instantiated once; all state lives in decode_stage.

Verification
REQ-031 Reset, then ADD r3,r1,r2 (r1=0x0005, r2=0x0007) valid -> next cycle o_valid=1, o_rdst=3, o_data1=0x0005, o_data2=0x0007, o_reg_write=1.
REQ-032 LDD r4 in EX (i_ex_mem_read=1, i_ex_rdst=4), decode ADD r5,r4,r1 -> o_ready=0 for one cycle, one o_valid=0 bubble, ADD issues the following cycle.
REQ-033 i_ex_stall=1 for 3 cycles with a valid instruction held in ID/EX -> all ID/EX outputs unchanged for 3 cycles, o_ready=0.
REQ-034 i_flush together with hazard -> o_valid=0 next cycle, FSM=RUN, o_ready=1 the cycle after.
REQ-035 With bypass: i_wb_write=1, i_wb_addr=2, i_wb_data=0xBEEF, decode reads r2 (rf holds 0x1111) -> o_data = 0xBEEF; without the macro -> 0x1111.
